uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a small memory-mapped register slave and TX FIFO.
// Bytes written to DATA are queued and shifted out as 8N1 frames, LSB first.
module uart_tx #(
  parameter int PRESCALE   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        UART_TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0]   BAUD_RELOAD = 16'(PRESCALE - 1);
  localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          busy;
  logic          sel_data;
  logic          data_write;
  logic          accept;
  logic          push;
  logic          pop;
  logic [7:0]    level_byte;
  logic [31:0]   status_word;
  logic [31:0]   read_word;
  logic          unused_bits;

  assign fifo_full   = (level == LEVEL_FULL);
  assign fifo_empty  = (level == '0);
  assign busy        = (state != IDLE);
  assign sel_data    = (i_address[3:2] == 2'd0);
  assign data_write  = i_rw && sel_data;
  assign accept      = i_request && !o_ready && !(data_write && fifo_full);
  assign push        = accept && data_write;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign level_byte  = 8'(level);
  assign status_word = {16'h0000, level_byte, 5'b00000, fifo_empty, fifo_full, busy};
  assign unused_bits = ^{i_address[31:4], i_address[1:0], i_wdata[31:8]};

  always_comb begin
    read_word = '0;
    if (i_address[3:2] == 2'd1) begin
      read_word = status_word;
    end
  end

  // o_ready stays high for as long as the master holds the request, so a
  // long request can never be accepted twice.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready <= 1'b0;
      o_rdata <= '0;
    end else if (accept) begin
      o_ready <= 1'b1;
      o_rdata <= i_rw ? '0 : read_word;
    end else if (!i_request) begin
      o_ready <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_wdata[7:0];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Each bit is exactly PRESCALE cycles: the counter reloads on the same edge
  // that drives the next bit onto the line.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      UART_TX   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= BAUD_RELOAD;
            UART_TX   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            baud_cnt  <= BAUD_RELOAD;
            bit_cnt   <= '0;
            UART_TX   <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              UART_TX <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              UART_TX   <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == '0) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: register-access vector table, then
// directed sequences for framing, FIFO stall, long requests and reset abort.
module tb_uart_tx;

  localparam int PRESCALE     = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int FRAME_CYCLES = 10 * PRESCALE;
  localparam int BUS_BOUND    = 200;
  localparam int NUM_VECS     = 9;

  logic        i_clock   = 1'b0;
  logic        i_reset   = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw      = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_wdata   = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        UART_TX;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        chk_rdata;
  } vec_t;

  vec_t vecs [NUM_VECS];

  uart_tx #(.PRESCALE(PRESCALE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_request (i_request),
    .i_rw      (i_rw),
    .i_address (i_address),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_ready   (o_ready),
    .UART_TX   (UART_TX)
  );

  always #5 i_clock = ~i_clock;

  // Line monitor: samples mid-bit on the falling edge and queues each byte
  // together with the cycle its start bit was first seen.
  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         cycle_cnt    = 0;
  int         mon_off      = -1;
  int         mon_start    = 0;
  int         framing_errs = 0;
  int         bit_idx;
  logic [7:0] mon_byte;

  always @(negedge i_clock) begin
    cycle_cnt++;
    if (!i_reset) begin
      mon_off = -1;
    end else if (mon_off < 0) begin
      if (UART_TX == 1'b0) begin
        mon_off   = 0;
        mon_start = cycle_cnt;
      end
    end else begin
      mon_off++;
      if (mon_off % PRESCALE == PRESCALE / 2) begin
        bit_idx = mon_off / PRESCALE;
        if (bit_idx == 0) begin
          if (UART_TX !== 1'b0) framing_errs++;
        end else if (bit_idx <= 8) begin
          mon_byte[bit_idx-1] = UART_TX;
        end else begin
          if (UART_TX !== 1'b1) framing_errs++;
          rx_q.push_back(mon_byte);
          rx_t.push_back(mon_start);
          mon_off = -1;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rw, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold,
                                output logic [31:0] rdata, output int lat,
                                output int drops);
    @(posedge i_clock); #1;
    i_request = 1'b1;
    i_rw      = rw;
    i_address = addr;
    i_wdata   = wdata;
    lat   = 0;
    drops = 0;
    do begin
      @(posedge i_clock); #1;
      lat++;
    end while (!o_ready && lat < BUS_BOUND);
    rdata = o_rdata;
    for (int i = 1; i < hold; i++) begin
      @(posedge i_clock); #1;
      if (!o_ready) drops++;
    end
    i_request = 1'b0;
    @(posedge i_clock); #1;
    check_output("ready_fall", {31'b0, o_ready}, 32'd0);
  endtask

  task automatic wait_frames(input int total);
    int budget;
    budget = 0;
    while (rx_q.size() < total && budget < 2000) begin
      @(posedge i_clock);
      budget++;
    end
    #1;
    check_output("frame_count", rx_q.size(), total);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    int          lat, drops, base, wait_cnt, wave_errs, gap;
    int          lats [6];

    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,          32'h0000_0004, 1'b1};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,          32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'h0,          32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_000C, 32'h1234_5678,  32'h0000_0000, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0004, 32'h0,          32'h0000_0004, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0014, 32'h0,          32'h0000_0004, 1'b1};
    vecs[8] = '{1'b0, 32'hFFFF_FFF8, 32'h0,          32'h0000_0000, 1'b1};

    repeat (3) @(posedge i_clock);
    #1;
    check_output("reset_tx", {31'b0, UART_TX}, 32'd1);
    check_output("reset_ready", {31'b0, o_ready}, 32'd0);
    check_output("reset_rdata", o_rdata, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    check_output("post_reset_tx", {31'b0, UART_TX}, 32'd1);
    check_output("post_reset_ready", {31'b0, o_ready}, 32'd0);

    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1, rd, lat, drops);
      check_output($sformatf("vec%0d_latency", i), lat, 32'd1);
      if (vecs[i].chk_rdata) check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Single byte: start bit follows the push by one cycle, every bit is 4 cycles.
    base = rx_q.size();
    apply_stimulus(1'b1, 32'h0, 32'h0000_00A5, 1, rd, lat, drops);
    check_output("a5_latency", lat, 32'd1);
    wait_cnt = 0;
    while (UART_TX !== 1'b0 && wait_cnt < 50) begin
      @(posedge i_clock); #1;
      wait_cnt++;
    end
    check_output("a5_start_delay", wait_cnt, 32'd0);
    frame = {1'b1, 8'hA5, 1'b0};
    wave_errs = 0;
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      if (UART_TX !== frame[i / PRESCALE]) wave_errs++;
      @(posedge i_clock); #1;
    end
    check_output("a5_waveform", wave_errs, 32'd0);
    check_output("a5_line_idle", {31'b0, UART_TX}, 32'd1);
    wait_frames(base + 1);
    check_output("a5_byte", {24'b0, rx_q[base]}, 32'h0000_00A5);

    // Burst: byte 1 goes straight into the shifter, bytes 2..5 fill the FIFO,
    // so byte 6 stalls until frame 1 ends and byte 2 is popped.
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 32'h0, 32'(i + 1), 1, rd, lat, drops);
      lats[i] = lat;
    end
    for (int i = 0; i < 5; i++) check_output($sformatf("burst_lat%0d", i), lats[i], 32'd1);
    check_output("burst_stall_lat", lats[5], 32'd29);
    wait_frames(base + 6);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("burst_byte%0d", i), {24'b0, rx_q[base+i]}, 32'(i + 1));
    end
    for (int i = 1; i < 6; i++) begin
      gap = rx_t[base+i] - rx_t[base+i-1];
      check_output($sformatf("burst_gap%0d", i),
                   {31'b0, (gap >= FRAME_CYCLES && gap <= FRAME_CYCLES + 1)}, 32'd1);
    end

    // STATUS mid-frame with two bytes waiting behind the active one.
    repeat (10) @(posedge i_clock);
    base = rx_q.size();
    apply_stimulus(1'b1, 32'h0, 32'h11, 1, rd, lat, drops);
    apply_stimulus(1'b1, 32'h0, 32'h22, 1, rd, lat, drops);
    apply_stimulus(1'b1, 32'h0, 32'h33, 1, rd, lat, drops);
    apply_stimulus(1'b0, 32'h4, 32'h0, 1, rd, lat, drops);
    check_output("status_midframe", rd, 32'h0000_0201);
    wait_frames(base + 3);
    check_output("status_byte0", {24'b0, rx_q[base]},   32'h11);
    check_output("status_byte2", {24'b0, rx_q[base+2]}, 32'h33);

    // Long request: one push however long it is held.
    repeat (10) @(posedge i_clock);
    base = rx_q.size();
    apply_stimulus(1'b1, 32'h0, 32'h5A, 10, rd, lat, drops);
    check_output("hold_latency", lat, 32'd1);
    check_output("hold_ready_drops", drops, 32'd0);
    repeat (200) @(posedge i_clock);
    #1;
    check_output("hold_frame_count", rx_q.size() - base, 32'd1);
    check_output("hold_byte", {24'b0, rx_q[base]}, 32'h5A);

    // Reset during data bit 3 of 0x30 (a 0 bit) with two bytes queued.
    base = rx_q.size();
    apply_stimulus(1'b1, 32'h0, 32'h30, 1, rd, lat, drops);
    apply_stimulus(1'b1, 32'h0, 32'h7E, 1, rd, lat, drops);
    apply_stimulus(1'b1, 32'h0, 32'h81, 1, rd, lat, drops);
    wait_cnt = 0;
    do begin
      @(negedge i_clock); #1;
      wait_cnt++;
    end while (mon_off != 4 * PRESCALE + PRESCALE / 2 && wait_cnt < 200);
    check_output("reset_bit3_reached", {31'b0, wait_cnt < 200}, 32'd1);
    #2;
    check_output("bit3_low", {31'b0, UART_TX}, 32'd0);
    i_reset = 1'b0;
    #1;
    check_output("async_reset_tx", {31'b0, UART_TX}, 32'd1);
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    apply_stimulus(1'b0, 32'h4, 32'h0, 1, rd, lat, drops);
    check_output("post_abort_status", rd, 32'h0000_0004);
    repeat (200) @(posedge i_clock);
    #1;
    check_output("post_abort_frames", rx_q.size() - base, 32'd0);
    check_output("framing_errors", framing_errs, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
